// File: rtl/ray_generator_if.sv
// Ray generator handshake bundle: frame control in, ray stream out.
interface ray_generator_if;
  logic        start;
  logic [27:0] cam_pos;
  logic        ray_ready;
  logic        ray_valid;
  logic [27:0] init;
  logic [30:0] dir;
  logic [9:0]  pix_x;
  logic [8:0]  pix_y;
  logic        busy;
  logic        frame_done;

  modport master (
    output start, cam_pos, ray_ready,
    input  ray_valid, init, dir, pix_x, pix_y, busy, frame_done
  );
  modport slave (
    input  start, cam_pos, ray_ready,
    output ray_valid, init, dir, pix_x, pix_y, busy, frame_done
  );
endinterface

// File: rtl/ray_generator.sv
// Raster-scan primary ray generator: one ray per pixel per handshake, with
// direction {pix_x - H/2, V/2 - pix_y, FOCAL} registered alongside the pixel.
module ray_generator #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int FOCAL = 256
) (
  input logic             clk,
  input logic             rst,
  ray_generator_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [10:0] HALF_H = 11'(H_RES / 2);
  localparam logic [10:0] HALF_V = 11'(V_RES / 2);
  localparam logic [8:0]  DZ     = 9'(FOCAL);
  localparam logic [9:0]  LAST_X = 10'(H_RES - 1);
  localparam logic [8:0]  LAST_Y = 9'(V_RES - 1);

  state_e      state_q, state_d;
  logic [9:0]  px_q, px_d;
  logic [8:0]  py_q, py_d;
  logic [27:0] init_q, init_d;
  logic [30:0] dir_q, dir_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  function automatic logic [30:0] ray_dir(input logic [9:0] x, input logic [8:0] y);
    logic [10:0] dx, dy;
    dx = {1'b0, x} - HALF_H;
    dy = HALF_V - {2'b00, y};
    return {dx, dy, DZ};
  endfunction

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    py_d    = py_q;
    init_d  = init_q;
    dir_d   = dir_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          init_d  = bus.cam_pos;
          px_d    = '0;
          py_d    = '0;
          dir_d   = ray_dir(10'd0, 9'd0);
          valid_d = 1'b1;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (valid_q && bus.ray_ready) begin
          // Last pixel keeps its coordinates; only the valid/busy flags drop.
          if (px_q == LAST_X && py_q == LAST_Y) begin
            valid_d = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            if (px_q == LAST_X) begin
              px_d = '0;
              py_d = py_q + 9'd1;
            end else begin
              px_d = px_q + 10'd1;
            end
            dir_d = ray_dir(px_d, py_d);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      px_q    <= '0;
      py_q    <= '0;
      init_q  <= '0;
      dir_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      py_q    <= py_d;
      init_q  <= init_d;
      dir_q   <= dir_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.ray_valid  = valid_q;
  assign bus.init       = init_q;
  assign bus.dir        = dir_q;
  assign bus.pix_x      = px_q;
  assign bus.pix_y      = py_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
endmodule
